// File: rtl/imp_tile_sched.sv
// rtl/imp_tile_sched.sv - frame-to-tile sequencer driving the image AXI read master
module imp_tile_sched #(
  parameter int              TO_W   = 16,
  parameter logic [TO_W-1:0] TO_CYC = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic        cfg_abort,
  input  logic [7:0]  cfg_frm_w,
  input  logic [7:0]  cfg_frm_h,
  input  logic [7:0]  cfg_tile_w,
  input  logic [7:0]  cfg_tile_h,
  input  logic [31:0] cfg_src_baddr,
  input  logic [31:0] cfg_dst_baddr,
  input  logic [8:0]  cfg_pitch,
  output logic [7:0]  imp_hsize,
  output logic [7:0]  imp_vsize,
  output logic [7:0]  imp_coor_minx,
  output logic [7:0]  imp_coor_miny,
  output logic [31:0] imp_src_baddr,
  output logic [31:0] imp_dst_baddr,
  output logic [8:0]  imp_adr_pitch,
  output logic        imp_st,
  input  logic        imp_done,
  output logic        busy,
  output logic        frame_done,
  output logic        err_timeout,
  output logic [15:0] tile_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_START, S_WAIT, S_NEXT, S_DONE, S_ERR
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_CYC - TO_W'(1);

  state_t          state_q, state_d;
  logic [7:0]      frm_w_q, frm_w_d, frm_h_q, frm_h_d;
  logic [7:0]      tile_w_q, tile_w_d, tile_h_q, tile_h_d;
  logic [31:0]     src_q, src_d, dst_q, dst_d;
  logic [8:0]      pitch_q, pitch_d;
  logic [8:0]      x_q, x_d, y_q, y_d;
  logic [15:0]     tile_idx_q, tile_idx_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            done_prev_q, done_prev_d;
  logic            err_q, err_d;
  logic [7:0]      hsize_q, hsize_d, vsize_q, vsize_d;
  logic [31:0]     imp_src_q, imp_src_d, imp_dst_q, imp_dst_d;
  logic [8:0]      imp_pitch_q, imp_pitch_d;

  logic [8:0]  x_n, y_n, rem_w, rem_h;
  logic [17:0] row_off;
  logic [31:0] tile_off;
  logic        accept, empty, done_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      frm_w_q     <= '0;
      frm_h_q     <= '0;
      tile_w_q    <= '0;
      tile_h_q    <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      pitch_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      tile_idx_q  <= '0;
      cnt_q       <= '0;
      done_prev_q <= 1'b0;
      err_q       <= 1'b0;
      hsize_q     <= '0;
      vsize_q     <= '0;
      imp_src_q   <= '0;
      imp_dst_q   <= '0;
      imp_pitch_q <= '0;
    end else begin
      state_q     <= state_d;
      frm_w_q     <= frm_w_d;
      frm_h_q     <= frm_h_d;
      tile_w_q    <= tile_w_d;
      tile_h_q    <= tile_h_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      pitch_q     <= pitch_d;
      x_q         <= x_d;
      y_q         <= y_d;
      tile_idx_q  <= tile_idx_d;
      cnt_q       <= cnt_d;
      done_prev_q <= done_prev_d;
      err_q       <= err_d;
      hsize_q     <= hsize_d;
      vsize_q     <= vsize_d;
      imp_src_q   <= imp_src_d;
      imp_dst_q   <= imp_dst_d;
      imp_pitch_q <= imp_pitch_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frm_w_d     = frm_w_q;
    frm_h_d     = frm_h_q;
    tile_w_d    = tile_w_q;
    tile_h_d    = tile_h_q;
    src_d       = src_q;
    dst_d       = dst_q;
    pitch_d     = pitch_q;
    x_d         = x_q;
    y_d         = y_q;
    tile_idx_d  = tile_idx_q;
    cnt_d       = cnt_q;
    done_prev_d = imp_done;
    err_d       = err_q;
    hsize_d     = hsize_q;
    vsize_d     = vsize_q;
    imp_src_d   = imp_src_q;
    imp_dst_d   = imp_dst_q;
    imp_pitch_d = imp_pitch_q;

    // x < frm_w whenever a tile is set up, so the remainders never underflow
    x_n       = x_q + {1'b0, tile_w_q};
    y_n       = y_q + {1'b0, tile_h_q};
    rem_w     = {1'b0, frm_w_q} - x_q;
    rem_h     = {1'b0, frm_h_q} - y_q;
    row_off   = 18'(y_q) * 18'(pitch_q);
    tile_off  = {14'd0, row_off} + {21'd0, x_q, 2'b00};
    empty     = (frm_w_q == 8'd0) || (frm_h_q == 8'd0) ||
                (tile_w_q == 8'd0) || (tile_h_q == 8'd0);
    done_rise = imp_done && !done_prev_q;
    accept    = cfg_start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

    if (cfg_abort) begin
      state_d = S_IDLE;
    end else if (accept) begin
      frm_w_d    = cfg_frm_w;
      frm_h_d    = cfg_frm_h;
      tile_w_d   = cfg_tile_w;
      tile_h_d   = cfg_tile_h;
      src_d      = cfg_src_baddr;
      dst_d      = cfg_dst_baddr;
      pitch_d    = cfg_pitch;
      x_d        = '0;
      y_d        = '0;
      tile_idx_d = '0;
      err_d      = 1'b0;
      state_d    = S_SETUP;
    end else begin
      case (state_q)
        S_SETUP: begin
          if (empty) begin
            state_d = S_DONE;
          end else begin
            hsize_d     = ({1'b0, tile_w_q} < rem_w) ? tile_w_q : rem_w[7:0];
            vsize_d     = ({1'b0, tile_h_q} < rem_h) ? tile_h_q : rem_h[7:0];
            imp_src_d   = src_q + tile_off;
            imp_dst_d   = dst_q + tile_off;
            imp_pitch_d = pitch_q;
            state_d     = S_START;
          end
        end
        S_START: begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // a done edge in the final timeout cycle still completes the tile
          if (done_rise) begin
            state_d = S_NEXT;
          end else if (cnt_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
        S_NEXT: begin
          if (x_n >= {1'b0, frm_w_q}) begin
            x_d = '0;
            y_d = y_n;
            if (y_n >= {1'b0, frm_h_q}) begin
              state_d = S_DONE;
            end else begin
              tile_idx_d = tile_idx_q + 16'd1;
              state_d    = S_SETUP;
            end
          end else begin
            x_d        = x_n;
            tile_idx_d = tile_idx_q + 16'd1;
            state_d    = S_SETUP;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign imp_hsize     = hsize_q;
  assign imp_vsize     = vsize_q;
  assign imp_coor_minx = 8'd0;
  assign imp_coor_miny = 8'd0;
  assign imp_src_baddr = imp_src_q;
  assign imp_dst_baddr = imp_dst_q;
  assign imp_adr_pitch = imp_pitch_q;
  assign imp_st        = (state_q == S_START) && !cfg_abort;
  assign frame_done    = (state_q == S_DONE) && !cfg_abort;
  assign busy          = (state_q == S_SETUP) || (state_q == S_START) ||
                         (state_q == S_WAIT) || (state_q == S_NEXT);
  assign err_timeout   = err_q;
  assign tile_idx      = tile_idx_q;

endmodule

// File: tb/tb_imp_tile_sched.sv
// tb/tb_imp_tile_sched.sv - directed scoreboard bench for imp_tile_sched
module tb_imp_tile_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start, cfg_abort;
  logic [7:0]  cfg_frm_w, cfg_frm_h, cfg_tile_w, cfg_tile_h;
  logic [31:0] cfg_src_baddr, cfg_dst_baddr;
  logic [8:0]  cfg_pitch;
  logic [7:0]  imp_hsize, imp_vsize, imp_coor_minx, imp_coor_miny;
  logic [31:0] imp_src_baddr, imp_dst_baddr;
  logic [8:0]  imp_adr_pitch;
  logic        imp_st, imp_done, busy, frame_done, err_timeout;
  logic [15:0] tile_idx;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    logic [7:0]  hs;
    logic [7:0]  vs;
    logic [31:0] src;
    logic [31:0] dst;
    logic [8:0]  pitch;
    logic [15:0] idx;
  } exp_t;
  exp_t sb[$];

  imp_tile_sched #(.TO_W(16), .TO_CYC(16'd20)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_frm_w(cfg_frm_w), .cfg_frm_h(cfg_frm_h), .cfg_tile_w(cfg_tile_w),
    .cfg_tile_h(cfg_tile_h), .cfg_src_baddr(cfg_src_baddr), .cfg_dst_baddr(cfg_dst_baddr),
    .cfg_pitch(cfg_pitch), .imp_hsize(imp_hsize), .imp_vsize(imp_vsize),
    .imp_coor_minx(imp_coor_minx), .imp_coor_miny(imp_coor_miny),
    .imp_src_baddr(imp_src_baddr), .imp_dst_baddr(imp_dst_baddr),
    .imp_adr_pitch(imp_adr_pitch), .imp_st(imp_st), .imp_done(imp_done),
    .busy(busy), .frame_done(frame_done), .err_timeout(err_timeout), .tile_idx(tile_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic push(input logic [7:0] hs, input logic [7:0] vs, input logic [31:0] src,
                      input logic [31:0] dst, input logic [8:0] pitch, input logic [15:0] idx);
    exp_t e;
    e.hs = hs; e.vs = vs; e.src = src; e.dst = dst; e.pitch = pitch; e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic set_cfg(input logic [7:0] fw, input logic [7:0] fh, input logic [7:0] tw,
                         input logic [7:0] th, input logic [31:0] src, input logic [31:0] dst,
                         input logic [8:0] pitch);
    cfg_frm_w = fw; cfg_frm_h = fh; cfg_tile_w = tw; cfg_tile_h = th;
    cfg_src_baddr = src; cfg_dst_baddr = dst; cfg_pitch = pitch;
  endtask

  task automatic start_frame();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // waits (bounded) for imp_st, then pops and compares one scoreboard entry
  task automatic wait_st(output int lat);
    exp_t e;
    lat = 0;
    while (imp_st !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    chk("st_seen", imp_st, 1'b1);
    chk("sb_nonempty", sb.size() > 0, 1'b1);
    if (imp_st === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("hsize[%0d]", e.idx), imp_hsize, e.hs);
      chk($sformatf("vsize[%0d]", e.idx), imp_vsize, e.vs);
      chk($sformatf("src[%0d]", e.idx), imp_src_baddr, e.src);
      chk($sformatf("dst[%0d]", e.idx), imp_dst_baddr, e.dst);
      chk($sformatf("pitch[%0d]", e.idx), imp_adr_pitch, e.pitch);
      chk($sformatf("coor[%0d]", e.idx), {imp_coor_minx, imp_coor_miny}, 16'd0);
      chk($sformatf("tile_idx[%0d]", e.idx), tile_idx, e.idx);
    end
  endtask

  // low for one cycle then high: the rise is sampled at the next edge; returns in NEXT
  task automatic pulse_done();
    imp_done = 1'b0;
    tick();
    imp_done = 1'b1;
    tick();
    imp_done = 1'b0;
  endtask

  task automatic frame_end(input logic [15:0] last_idx);
    chk("fd_in_next", frame_done, 1'b0);
    tick();
    chk("frame_done", frame_done, 1'b1);
    chk("busy_done", busy, 1'b0);
    chk("tile_idx_last", tile_idx, last_idx);
    tick();
    chk("fd_one_cycle", frame_done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    logic seen_st, seen_fd;

    rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; imp_done = 1'b0;
    set_cfg(8'd0, 8'd0, 8'd0, 8'd0, 32'd0, 32'd0, 9'd0);
    tick(); tick();
    chk("rst_imp", {imp_hsize, imp_vsize, imp_src_baddr, imp_dst_baddr}, 64'd0);
    chk("rst_pitch", imp_adr_pitch, 9'd0);
    chk("rst_flags", {imp_st, busy, frame_done, err_timeout}, 4'd0);
    chk("rst_tile_idx", tile_idx, 16'd0);
    rst = 1'b0;
    tick();

    // 64x64 frame, 32x32 tiles
    set_cfg(8'd64, 8'd64, 8'd32, 8'd32, 32'h1000, 32'h8000, 9'd256);
    push(8'd32, 8'd32, 32'h1000, 32'h8000, 9'd256, 16'd0);
    push(8'd32, 8'd32, 32'h1080, 32'h8080, 9'd256, 16'd1);
    push(8'd32, 8'd32, 32'h3000, 32'hA000, 9'd256, 16'd2);
    push(8'd32, 8'd32, 32'h3080, 32'hA080, 9'd256, 16'd3);
    start_frame();
    chk("busy_setup", busy, 1'b1);
    for (int t = 0; t < 4; t++) begin
      wait_st(lat);
      pulse_done();
    end
    frame_end(16'd3);

    // 40x20 frame, 32x16 tiles: edge tiles are clipped
    set_cfg(8'd40, 8'd20, 8'd32, 8'd16, 32'h2000, 32'h9000, 9'd100);
    push(8'd32, 8'd16, 32'h2000, 32'h9000, 9'd100, 16'd0);
    push(8'd8,  8'd16, 32'h2080, 32'h9080, 9'd100, 16'd1);
    push(8'd32, 8'd4,  32'h2640, 32'h9640, 9'd100, 16'd2);
    push(8'd8,  8'd4,  32'h26C0, 32'h96C0, 9'd100, 16'd3);
    start_frame();
    for (int t = 0; t < 4; t++) begin
      wait_st(lat);
      pulse_done();
    end
    frame_end(16'd3);

    // done already high across START must not complete the tile
    set_cfg(8'd64, 8'd32, 8'd32, 8'd32, 32'h0, 32'h100, 9'd64);
    push(8'd32, 8'd32, 32'h0,  32'h100, 9'd64, 16'd0);
    push(8'd32, 8'd32, 32'h80, 32'h180, 9'd64, 16'd1);
    imp_done = 1'b1;
    start_frame();
    wait_st(lat);
    seen_st = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen_st |= imp_st;
    end
    chk("held_done_no_st", seen_st, 1'b0);
    chk("held_done_busy", busy, 1'b1);
    chk("held_done_idx", tile_idx, 16'd0);
    imp_done = 1'b0;
    tick();
    imp_done = 1'b1;
    wait_st(lat);
    chk("done_to_st_lat", lat, 3);
    pulse_done();
    frame_end(16'd1);

    // timeout with done never rising
    imp_done = 1'b0;
    set_cfg(8'd64, 8'd64, 8'd32, 8'd32, 32'h4000, 32'hC000, 9'd128);
    push(8'd32, 8'd32, 32'h4000, 32'hC000, 9'd128, 16'd0);
    start_frame();
    wait_st(lat);
    n = 0; seen_fd = 1'b0;
    while (err_timeout !== 1'b1 && n < 100) begin
      tick();
      n++;
      seen_fd |= frame_done;
      if (n == 20) chk("busy_wait20", busy, 1'b1);
    end
    chk("timeout_cycles", n, 21);
    chk("err_timeout", err_timeout, 1'b1);
    chk("busy_err", busy, 1'b0);
    chk("no_fd_on_err", seen_fd, 1'b0);
    tick(); tick();
    chk("err_sticky", err_timeout, 1'b1);

    // restart clears the error; then ignored start and abort in tile 2
    set_cfg(8'd64, 8'd64, 8'd32, 8'd32, 32'h1000, 32'h8000, 9'd256);
    push(8'd32, 8'd32, 32'h1000, 32'h8000, 9'd256, 16'd0);
    push(8'd32, 8'd32, 32'h1080, 32'h8080, 9'd256, 16'd1);
    push(8'd32, 8'd32, 32'h3000, 32'hA000, 9'd256, 16'd2);
    start_frame();
    chk("err_cleared", err_timeout, 1'b0);
    for (int t = 0; t < 2; t++) begin
      wait_st(lat);
      pulse_done();
    end
    wait_st(lat);
    tick();
    set_cfg(8'd8, 8'd8, 8'd4, 8'd4, 32'h0, 32'h0, 9'd16);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("ign_start_busy", busy, 1'b1);
    chk("ign_start_idx", tile_idx, 16'd2);
    chk("ign_start_hsize", imp_hsize, 8'd32);
    tick();
    chk("ign_start_no_st", imp_st, 1'b0);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_idx", tile_idx, 16'd2);
    chk("abort_err", err_timeout, 1'b0);
    seen_st = 1'b0; seen_fd = 1'b0;
    for (int i = 0; i < 30; i++) begin
      imp_done = i[2];
      tick();
      seen_st |= imp_st;
      seen_fd |= frame_done;
    end
    chk("abort_no_st", seen_st, 1'b0);
    chk("abort_no_fd", seen_fd, 1'b0);
    imp_done = 1'b0;

    // empty frame: SETUP then DONE, no launch
    set_cfg(8'd0, 8'd64, 8'd32, 8'd32, 32'h1000, 32'h8000, 9'd256);
    start_frame();
    chk("empty_setup", {imp_st, frame_done, busy}, 3'b001);
    tick();
    chk("empty_done", {imp_st, frame_done, busy}, 3'b010);
    tick();
    chk("empty_fd_end", frame_done, 1'b0);

    // reset in the middle of a frame
    set_cfg(8'd64, 8'd64, 8'd32, 8'd32, 32'h1000, 32'h8000, 9'd256);
    push(8'd32, 8'd32, 32'h1000, 32'h8000, 9'd256, 16'd0);
    start_frame();
    wait_st(lat);
    pulse_done();
    rst = 1'b1;
    tick();
    chk("mid_rst_imp", {imp_hsize, imp_vsize, imp_src_baddr, imp_dst_baddr}, 64'd0);
    chk("mid_rst_flags", {imp_st, busy, frame_done, err_timeout}, 4'd0);
    chk("mid_rst_idx", tile_idx, 16'd0);
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_idle", {imp_st, busy}, 2'd0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/imp_tile_sched.md
Name: imp_tile_sched

Overview:
Frame-level sequencer for the image-processing AXI read master. It splits a frame into rectangular tiles and programs the master's task configuration once per tile. For each tile it pulses the master's start, waits for its done, then advances to the next tile. It sits between the CPU-visible config registers and the master, and reports frame completion and timeout errors.

Parameters:
TO_W, 16, width of the per-tile timeout counter
TO_CYC, 16'hFFFF, cycles in WAIT without a done rising edge before a timeout error

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_start  in  1  1-cycle frame start pulse
cfg_abort  in  1  1-cycle abort pulse
cfg_frm_w  in  8  frame width in pixels
cfg_frm_h  in  8  frame height in rows
cfg_tile_w  in  8  tile width in pixels
cfg_tile_h  in  8  tile height in rows
cfg_src_baddr  in  32  frame source base address
cfg_dst_baddr  in  32  frame destination base address
cfg_pitch  in  9  bytes per row
imp_hsize  out  8  tile width sent to the master
imp_vsize  out  8  tile height sent to the master
imp_coor_minx  out  8  tile X start, always 0
imp_coor_miny  out  8  tile Y start, always 0
imp_src_baddr  out  32  tile source address
imp_dst_baddr  out  32  tile destination address
imp_adr_pitch  out  9  pitch passed to the master
imp_st  out  1  1-cycle start pulse to the master
imp_done  in  1  master done, a level signal
busy  out  1  high from the start-accept cycle until DONE, ERR or abort
frame_done  out  1  1-cycle pulse when the last tile completes
err_timeout  out  1  sticky timeout flag
tile_idx  out  16  index of the current or last launched tile

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0: imp_*, busy, frame_done, err_timeout, tile_idx.
- cfg_start is accepted only in IDLE, DONE or ERR; it is ignored while busy.
- On accept, the block latches all cfg_*. It clears err_timeout, x, y and tile_idx, sets busy=1, and moves to SETUP.
- Empty frame: if any latched size is 0, the FSM goes SETUP -> DONE. No imp_st is issued.
- SETUP (1 cycle): registers the tile configuration from the current x and y.
  - imp_hsize = min(tile_w, frm_w - x); imp_vsize = min(tile_h, frm_h - y).
  - imp_src_baddr = src_baddr + y*pitch + x*4, computed in 32-bit with wrap on overflow.
  - imp_dst_baddr uses the same formula with dst_baddr.
  - imp_adr_pitch = pitch; imp_coor_minx and imp_coor_miny are 0.
  - Next state is START.
- START (1 cycle): imp_st=1, then the FSM enters WAIT. imp_* stay stable from SETUP until the next SETUP.
- WAIT: a tile completes only on a rising edge of imp_done, detected as imp_done=1 while a registered copy is 0.
  - A done level that is already high on entry, or stays high, does not complete the tile. A fall followed by a rise is required.
  - The timeout counter is cleared on entry and increments every WAIT cycle.
- Timeout: when the counter reaches TO_CYC with no rising edge, the FSM enters ERR with err_timeout=1 and busy=0. No frame_done is issued.
- If a done rising edge and the timeout fall in the same cycle, the done edge wins.
- NEXT (1 cycle, entered on the done edge): x_n = x + tile_w.
  - If x_n >= frm_w: x = 0 and y = y + tile_h, else x = x_n.
  - If the new y >= frm_h, go to DONE. Otherwise tile_idx increments and the FSM returns to SETUP.
  - x and y are held 9 bits wide so the sums cannot wrap.
- DONE: frame_done=1 for exactly 1 cycle and busy=0, then IDLE.
- Abort: cfg_abort in any state forces IDLE on the next edge with busy=0. imp_st is 0 in that cycle, no frame_done is issued, and err_timeout is unchanged. Abort has priority over start in the same cycle.
- Tile-to-tile overhead: done edge to the next imp_st is 3 cycles (NEXT, SETUP, START).
- A reset mid-frame behaves exactly like the reset values above.

Test Plan:
- 64x64 frame, 32x32 tiles, src=0x1000, dst=0x8000, pitch=256 -> 4 imp_st pulses.
  - src addresses: 0x1000, 0x1080, 0x3000, 0x3080; dst addresses offset by the same amounts.
  - frame_done 1 cycle after the 4th done edge; tile_idx=3.
- 40x20 frame, 32x16 tiles -> (hsize,vsize) sequence (32,16), (8,16), (32,4), (8,4). The 3rd src address = src + 16*pitch.
- imp_done held high before and across START -> no advance. Drop done 1 cycle, then raise it -> NEXT, then imp_st exactly 3 cycles later.
- TO_CYC=20 with done never asserted -> ERR with err_timeout=1 and busy=0 at the 20th WAIT cycle, no frame_done. A new cfg_start clears err_timeout.
- Abort in WAIT of tile 2 -> IDLE next cycle with busy=0, no further imp_st. cfg_start while busy is ignored, and tile_idx is unchanged.
- frm_w=0 -> no imp_st; frame_done 2 cycles after start (SETUP, DONE).
